// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard: two combinational read ports,
// one writeback port with optional forwarding, and issue/flush control of busy bits.
module reg_file_sb #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [AW-1:0] RAddr1,
  input  logic [AW-1:0] RAddr2,
  output logic [DW-1:0] RVal1,
  output logic [DW-1:0] RVal2,
  output logic          RBusy1,
  output logic          RBusy2,
  input  logic          WEn,
  input  logic [AW-1:0] WAddr,
  input  logic [DW-1:0] WVal,
  input  logic          IssEn,
  input  logic [AW-1:0] IssAddr,
  input  logic          Flush,
  output logic [AW:0]   BusyCnt
);

  localparam int unsigned NREG = 2**AW;
  localparam int unsigned CW   = AW + 1;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic            wr_ok;
  logic            iss_ok;
  logic            fwd1;
  logic            fwd2;

  // Register 0 is hardwired: neither a write target nor a busy candidate
  assign wr_ok  = WEn && (WAddr != '0);
  assign iss_ok = IssEn && (IssAddr != '0);

  // Next busy vector: issue is applied after writeback so a new producer wins
  always_comb begin
    busy_nxt = busy;
    if (Flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_ok) busy_nxt[WAddr] = 1'b0;
      if (iss_ok) busy_nxt[IssAddr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 1; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      busy    <= '0;
      BusyCnt <= '0;
    end else begin
      busy    <= busy_nxt;
      BusyCnt <= cnt_nxt;
    end
  end

  // Data storage; a write lands even in a flush cycle
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[WAddr] <= WVal;
    end
  end

  assign fwd1 = BYPASS && wr_ok && (WAddr == RAddr1);
  assign fwd2 = BYPASS && wr_ok && (WAddr == RAddr2);

  // Read ports: forwarded writeback data also hides the busy bit it retires
  always_comb begin
    RVal1  = '0;
    RBusy1 = 1'b0;
    if (RAddr1 != '0) begin
      RVal1  = fwd1 ? WVal : regs[RAddr1];
      RBusy1 = busy[RAddr1] && !fwd1;
    end
  end

  always_comb begin
    RVal2  = '0;
    RBusy2 = 1'b0;
    if (RAddr2 != '0) begin
      RVal2  = fwd2 ? WVal : regs[RAddr2];
      RBusy2 = busy[RAddr2] && !fwd2;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: forwarding and non-forwarding instances share stimulus and
// are checked every cycle against an array-based model, plus directed literal checks.
module tb_reg_file_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NREG = 2**AW;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic [AW-1:0] RAddr1 = '0, RAddr2 = '0;
  logic          WEn = 1'b0;
  logic [AW-1:0] WAddr = '0;
  logic [DW-1:0] WVal = '0;
  logic          IssEn = 1'b0;
  logic [AW-1:0] IssAddr = '0;
  logic          Flush = 1'b0;

  logic [DW-1:0] a_rval1, a_rval2, b_rval1, b_rval2;
  logic          a_rbusy1, a_rbusy2, b_rbusy1, b_rbusy2;
  logic [AW:0]   a_cnt, b_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  bit [DW-1:0] m_regs [NREG];
  bit          m_busy [NREG];

  always #5 Clk = ~Clk;

  reg_file_sb #(.DW(DW), .AW(AW), .BYPASS(1'b1)) dut_a (
    .Clk(Clk), .Rst(Rst), .RAddr1(RAddr1), .RAddr2(RAddr2),
    .RVal1(a_rval1), .RVal2(a_rval2), .RBusy1(a_rbusy1), .RBusy2(a_rbusy2),
    .WEn(WEn), .WAddr(WAddr), .WVal(WVal), .IssEn(IssEn), .IssAddr(IssAddr),
    .Flush(Flush), .BusyCnt(a_cnt)
  );

  reg_file_sb #(.DW(DW), .AW(AW), .BYPASS(1'b0)) dut_b (
    .Clk(Clk), .Rst(Rst), .RAddr1(RAddr1), .RAddr2(RAddr2),
    .RVal1(b_rval1), .RVal2(b_rval2), .RBusy1(b_rbusy1), .RBusy2(b_rbusy2),
    .WEn(WEn), .WAddr(WAddr), .WVal(WVal), .IssEn(IssEn), .IssAddr(IssAddr),
    .Flush(Flush), .BusyCnt(b_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural state only
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (Flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      end else begin
        if (WEn && WAddr != 0) m_busy[WAddr] = 1'b0;
        if (IssEn && IssAddr != 0) m_busy[IssAddr] = 1'b1;
      end
      if (WEn && WAddr != 0) m_regs[WAddr] = WVal;
    end
  end

  function automatic logic [DW-1:0] exp_val(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && WEn && WAddr == a) return WVal;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && WEn && WAddr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge Clk) begin
    chk("a.rval1", 64'(a_rval1), 64'(exp_val(RAddr1, 1'b1)));
    chk("a.rval2", 64'(a_rval2), 64'(exp_val(RAddr2, 1'b1)));
    chk("a.rbusy1", 64'(a_rbusy1), 64'(exp_busy(RAddr1, 1'b1)));
    chk("a.rbusy2", 64'(a_rbusy2), 64'(exp_busy(RAddr2, 1'b1)));
    chk("a.busycnt", 64'(a_cnt), 64'(exp_cnt()));
    chk("b.rval1", 64'(b_rval1), 64'(exp_val(RAddr1, 1'b0)));
    chk("b.rval2", 64'(b_rval2), 64'(exp_val(RAddr2, 1'b0)));
    chk("b.rbusy1", 64'(b_rbusy1), 64'(exp_busy(RAddr1, 1'b0)));
    chk("b.rbusy2", 64'(b_rbusy2), 64'(exp_busy(RAddr2, 1'b0)));
    chk("b.busycnt", 64'(b_cnt), 64'(exp_cnt()));
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    WEn = 1'b0;
    IssEn = 1'b0;
    Flush = 1'b0;
  endtask

  initial begin
    // Reset values across every address
    #2;
    for (int i = 0; i < NREG; i++) begin
      RAddr1 = AW'(i);
      RAddr2 = AW'(NREG - 1 - i);
      #1;
      chk("rst.rval1", 64'(a_rval1), 64'h0);
      chk("rst.rbusy2", 64'(b_rbusy2), 64'h0);
    end
    chk("rst.busycnt", 64'(a_cnt), 64'h0);
    step();
    step();
    Rst = 1'b1;

    // Write then read
    WEn = 1'b1; WAddr = 5'd3; WVal = 32'hDEADBEEF; RAddr1 = '0; RAddr2 = '0;
    step();
    idle(); RAddr1 = 5'd3; RAddr2 = 5'd0;
    #1;
    chk("wr.a.rval1", 64'(a_rval1), 64'hDEADBEEF);
    chk("wr.b.rval1", 64'(b_rval1), 64'hDEADBEEF);
    chk("wr.a.rval2", 64'(a_rval2), 64'h0);

    // Forwarding while the destination is busy
    IssEn = 1'b1; IssAddr = 5'd5;
    step();
    idle(); WEn = 1'b1; WAddr = 5'd5; WVal = 32'h12345678; RAddr1 = 5'd5;
    #1;
    chk("byp.a.rval1", 64'(a_rval1), 64'h12345678);
    chk("byp.a.rbusy1", 64'(a_rbusy1), 64'h0);
    chk("byp.b.rval1", 64'(b_rval1), 64'h0);
    chk("byp.b.rbusy1", 64'(b_rbusy1), 64'h1);
    step();
    idle();
    #1;
    chk("byp.b.after", 64'(b_rval1), 64'h12345678);

    // Scoreboard set and clear
    IssEn = 1'b1; IssAddr = 5'd7;
    step();
    idle(); RAddr1 = 5'd7;
    #1;
    chk("sb.rbusy1", 64'(a_rbusy1), 64'h1);
    chk("sb.cnt1", 64'(a_cnt), 64'h1);
    WEn = 1'b1; WAddr = 5'd7; WVal = 32'h00000777;
    step();
    idle();
    #1;
    chk("sb.cleared", 64'(a_rbusy1), 64'h0);
    chk("sb.cnt0", 64'(b_cnt), 64'h0);
    IssEn = 1'b1; IssAddr = 5'd0;
    step();
    idle();
    #1;
    chk("sb.r0cnt", 64'(a_cnt), 64'h0);

    // Issue and writeback collide
    IssEn = 1'b1; IssAddr = 5'd9; WEn = 1'b1; WAddr = 5'd9; WVal = 32'hA5A5A5A5;
    step();
    idle(); RAddr1 = 5'd9;
    #1;
    chk("col.rval", 64'(b_rval1), 64'hA5A5A5A5);
    chk("col.rbusy", 64'(a_rbusy1), 64'h1);
    chk("col.cnt", 64'(a_cnt), 64'h1);

    // Fill then flush with a simultaneous write
    for (int i = 1; i < NREG; i++) begin
      IssEn = 1'b1; IssAddr = AW'(i);
      step();
    end
    idle();
    #1;
    chk("fill.cnt", 64'(a_cnt), 64'd31);
    Flush = 1'b1; WEn = 1'b1; WAddr = 5'd4; WVal = 32'hCAFEF00D;
    step();
    idle(); RAddr1 = 5'd4; RAddr2 = 5'd4;
    #1;
    chk("fl.cnt", 64'(a_cnt), 64'h0);
    chk("fl.rval", 64'(b_rval1), 64'hCAFEF00D);
    chk("fl.rbusy", 64'(a_rbusy2), 64'h0);

    // Asynchronous reset mid-cycle with data and busy state present
    IssEn = 1'b1; IssAddr = 5'd3; WEn = 1'b1; WAddr = 5'd10; WVal = 32'h11111111;
    step();
    idle(); RAddr1 = 5'd3; RAddr2 = 5'd10;
    #2;
    chk("ar.pre", 64'(a_rval2), 64'h11111111);
    Rst = 1'b0;
    #1;
    chk("ar.rval1", 64'(a_rval1), 64'h0);
    chk("ar.rval2", 64'(b_rval2), 64'h0);
    chk("ar.rbusy1", 64'(a_rbusy1), 64'h0);
    chk("ar.cnt", 64'(b_cnt), 64'h0);
    WEn = 1'b1; WAddr = 5'd6; WVal = 32'h77; IssEn = 1'b1; IssAddr = 5'd6;
    step();
    #1;
    chk("ar.discard", 64'(b_cnt), 64'h0);
    Rst = 1'b1; RAddr1 = 5'd6; IssEn = 1'b0;
    #1;
    chk("ar.a.fwd", 64'(a_rval1), 64'h77);
    chk("ar.b.old", 64'(b_rval1), 64'h0);
    step();
    idle();
    #1;
    chk("ar.b.new", 64'(b_rval1), 64'h77);

    // Randomized traffic, biased to low addresses for more collisions
    for (int c = 0; c < 3000; c++) begin
      logic [AW-1:0] ra;
      ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      RAddr1  = ra;
      RAddr2  = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 7));
      WEn     = ($urandom_range(0, 1) == 1);
      WAddr   = ($urandom_range(0, 1) == 0) ? ra : AW'($urandom);
      WVal    = DW'($urandom);
      IssEn   = ($urandom_range(0, 9) < 4);
      IssAddr = ($urandom_range(0, 3) == 0) ? WAddr : AW'($urandom);
      Flush   = ($urandom_range(0, 63) == 0);
      Rst     = ($urandom_range(0, 299) != 0);
      #1;
      chk("rnd.same.val", 64'(a_rval1 == a_rval2), 64'(RAddr1 == RAddr2 ? 1'b1 : a_rval1 == a_rval2));
      step();
    end
    idle();
    Rst = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter AW, default 5, meaning address width; register count NREG = 2**AW.
REQ-003 The block SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding enabled (1) or disabled (0).
REQ-004 The block SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port Rst  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have ports RAddr1, RAddr2  input  AW  read addresses.
REQ-007 The block SHALL have ports RVal1, RVal2  output  DW  read data, combinational.
REQ-008 The block SHALL have ports RBusy1, RBusy2  output  1  addressed register has a pending producer.
REQ-009 The block SHALL have ports WEn (1), WAddr (AW) and WVal (DW), all inputs, forming the writeback port.
REQ-010 The block SHALL have ports IssEn (1) and IssAddr (AW), both inputs, marking a destination register busy at issue.
REQ-011 The block SHALL have port Flush  input  1  clear all busy bits.
REQ-012 The block SHALL have port BusyCnt  output  AW+1  number of registers currently busy.

Function
REQ-013 Register 0 SHALL read as zero, ignore writes, and never become busy.
REQ-014 On a rising Clk edge with WEn=1 and WAddr!=0, Regs[WAddr] SHALL take WVal.
REQ-015 With BYPASS=1, if WEn=1, WAddr==RAddrN and RAddrN!=0, then RValN SHALL equal WVal in the same cycle; otherwise RValN SHALL equal Regs[RAddrN].
REQ-016 With BYPASS=0, RValN SHALL equal Regs[RAddrN], so new data is visible the cycle after the write edge.
REQ-017 Each register r!=0 SHALL hold one busy bit, updated on the rising edge as: Flush -> 0; else IssEn & IssAddr==r -> 1; else WEn & WAddr==r -> 0; else hold.
REQ-018 When a set and a clear of the same register occur in the same cycle, the set SHALL win, because the new producer supersedes the write.
REQ-019 Flush SHALL take priority over IssEn and WEn for busy bits only; a WEn write in a Flush cycle SHALL still update Regs.
REQ-020 RBusyN SHALL equal busy[RAddrN], masked to 0 when RAddrN==0, and further masked to 0 when BYPASS=1 and WEn & WAddr==RAddrN.
REQ-021 BusyCnt SHALL be a registered count equal to the population count of the busy bits after each edge, and SHALL range from 0 to NREG-1.
REQ-022 A WEn to a non-busy register SHALL write data and leave the busy bits unchanged; this case is not an error.
REQ-023 Simultaneous reads of the same address on both ports SHALL return identical data and busy values.

Reset
REQ-024 While Rst=0, all Regs, all busy bits and BusyCnt SHALL be 0, immediately and without a clock edge.
REQ-025 Reset asserted mid-operation SHALL discard pending writes and issues in that cycle; the first edge after Rst rises SHALL behave normally.
REQ-026 After reset, RVal1, RVal2, RBusy1 and RBusy2 SHALL be 0 for every address.

Verification
REQ-027 Write then read: WEn=1, WAddr=3, WVal=0xDEADBEEF for one edge -> RAddr1=3 next cycle reads 0xDEADBEEF; RAddr2=0 reads 0.
REQ-028 Bypass: BYPASS=1, WEn=1, WAddr=5, WVal=0x12345678, RAddr1=5 in the same cycle -> RVal1=0x12345678 and RBusy1=0 before the edge; with BYPASS=0, RVal1 shows the old value.
REQ-029 Scoreboard: IssEn on addr 7 -> RBusy=1 and BusyCnt=1; a later WEn to 7 -> busy cleared and BusyCnt=0; IssEn to 0 -> BusyCnt stays 0.
REQ-030 Collision: IssEn and WEn both on addr 9 in one cycle -> Regs[9]=WVal, busy[9]=1, BusyCnt incremented by 1.
REQ-031 Flush: issue to addrs 1..31, then Flush with WEn to 4 -> BusyCnt=0 and Regs[4] updated; issuing all 31 first -> BusyCnt=31.
REQ-032 Async reset: drop Rst between edges with data loaded -> outputs read 0 immediately, with no Clk edge required.
